// File: rtl/branch_checkpoint_unit.sv
// Branch checkpoint buffer: holds per-branch rename snapshots in program order and,
// on a mispredict, reinstalls the branch's snapshot while squashing it and all younger ones.
module branch_checkpoint_unit #(
  parameter int DEPTH = 4,
  parameter int IDXW  = 2,
  parameter int TAGW  = 5,
  parameter int RDYW  = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            save_valid,
  input  logic [31:0]     save_pc,
  input  logic [TAGW-1:0] save_rob_tag,
  input  logic [RDYW-1:0] save_rdy_table,
  output logic            save_ready,
  output logic [IDXW-1:0] save_id,
  input  logic            resolve_valid,
  input  logic            resolve_mispredict,
  input  logic [TAGW-1:0] resolve_rob_tag,
  output logic            restore_valid,
  output logic [31:0]     restore_pc,
  output logic [TAGW-1:0] restore_rob_tag,
  output logic [RDYW-1:0] restore_rdy_table,
  output logic            flush,
  output logic [IDXW:0]   count,
  output logic            full,
  output logic            empty
);

  typedef enum logic [0:0] {IDLE = 1'b0, RECOVER = 1'b1} state_t;

  localparam logic [IDXW:0] DEPTH_P = (IDXW+1)'(DEPTH);
  localparam logic [IDXW:0] ONE_P   = (IDXW+1)'(1);

  state_t          state_r, state_s;
  logic [DEPTH-1:0] valid_r, valid_s, squash_s;
  logic [31:0]     pc_r  [DEPTH];
  logic [TAGW-1:0] tag_r [DEPTH];
  logic [RDYW-1:0] rdy_r [DEPTH];

  logic [IDXW:0]   head_r, head_s, tail_r, tail_s;
  logic [IDXW:0]   count_s, new_tail_s, squash_span_s;
  logic [IDXW-1:0] head_idx_s, tail_idx_s, match_idx_s;
  logic            match_s, mispredict_s, correct_s;
  logic            full_s, save_ready_s, save_fire_s, retire_s;

  logic            restore_valid_r;
  logic [31:0]     restore_pc_r;
  logic [TAGW-1:0] restore_tag_r;
  logic [RDYW-1:0] restore_rdy_r;

  assign head_idx_s = head_r[IDXW-1:0];
  assign tail_idx_s = tail_r[IDXW-1:0];
  assign count_s    = tail_r - head_r;
  assign full_s     = (count_s == DEPTH_P);

  // Tag lookup across live checkpoints; a slot being written this cycle is not yet valid.
  always_comb begin
    match_s     = 1'b0;
    match_idx_s = {IDXW{1'b0}};
    for (int j = 0; j < DEPTH; j++) begin
      if (!match_s && valid_r[j] && (tag_r[j] == resolve_rob_tag)) begin
        match_s     = 1'b1;
        match_idx_s = IDXW'(j);
      end else begin
        match_s     = match_s;
      end
    end
  end

  assign mispredict_s = (state_r == IDLE) && resolve_valid && resolve_mispredict && match_s;
  assign correct_s    = (state_r == IDLE) && resolve_valid && !resolve_mispredict && match_s;
  assign save_ready_s = (state_r == IDLE) && !full_s && !mispredict_s;
  assign save_fire_s  = save_valid && save_ready_s;
  assign retire_s     = (head_r != tail_r) && !valid_r[head_idx_s];

  // Rebuild tail from head so the wrap bit stays consistent; everything from it to old tail dies.
  assign new_tail_s    = head_r + {1'b0, match_idx_s - head_idx_s};
  assign squash_span_s = tail_r - new_tail_s;

  // Mark slots lying in the squashed span [match, old tail).
  always_comb begin
    squash_s = {DEPTH{1'b0}};
    for (int j = 0; j < DEPTH; j++) begin
      squash_s[j] = ({1'b0, IDXW'(j) - match_idx_s} < squash_span_s);
    end
  end

  // Recovery sequencing.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = mispredict_s ? RECOVER : IDLE;
      RECOVER: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next pointers and per-slot valid bits.
  always_comb begin
    head_s  = retire_s ? (head_r + ONE_P) : head_r;
    valid_s = valid_r;
    if (mispredict_s) begin
      tail_s = new_tail_s;
    end else if (save_fire_s) begin
      tail_s = tail_r + ONE_P;
    end else begin
      tail_s = tail_r;
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (mispredict_s && squash_s[j]) begin
        valid_s[j] = 1'b0;
      end else if (correct_s && (match_idx_s == IDXW'(j))) begin
        valid_s[j] = 1'b0;
      end else if (save_fire_s && (tail_idx_s == IDXW'(j))) begin
        valid_s[j] = 1'b1;
      end else begin
        valid_s[j] = valid_r[j];
      end
    end
  end

  // Control state, pointers and the restore bundle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      head_r          <= {(IDXW+1){1'b0}};
      tail_r          <= {(IDXW+1){1'b0}};
      valid_r         <= {DEPTH{1'b0}};
      restore_valid_r <= 1'b0;
      restore_pc_r    <= 32'h0;
      restore_tag_r   <= {TAGW{1'b0}};
      restore_rdy_r   <= {RDYW{1'b0}};
    end else begin
      state_r         <= state_s;
      head_r          <= head_s;
      tail_r          <= tail_s;
      valid_r         <= valid_s;
      restore_valid_r <= mispredict_s;
      if (mispredict_s) begin
        restore_pc_r  <= pc_r[match_idx_s];
        restore_tag_r <= tag_r[match_idx_s];
        restore_rdy_r <= rdy_r[match_idx_s];
      end
    end
  end

  // Checkpoint payload; only meaningful while the slot's valid bit is set.
  always_ff @(posedge clk) begin
    if (save_fire_s) begin
      pc_r[tail_idx_s]  <= save_pc;
      tag_r[tail_idx_s] <= save_rob_tag;
      rdy_r[tail_idx_s] <= save_rdy_table;
    end
  end

  assign save_ready        = save_ready_s;
  assign save_id           = tail_idx_s;
  assign restore_valid     = restore_valid_r;
  assign flush             = restore_valid_r;
  assign restore_pc        = restore_pc_r;
  assign restore_rob_tag   = restore_tag_r;
  assign restore_rdy_table = restore_rdy_r;
  assign count             = count_s;
  assign full              = full_s;
  assign empty             = (head_r == tail_r);

endmodule

// File: tb/tb_branch_checkpoint_unit.sv
// Bench for branch_checkpoint_unit: directed vector table for the planned scenarios,
// then randomized traffic against a slot/counter reference model.
module tb_branch_checkpoint_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         save_valid;
  logic [31:0]  save_pc;
  logic [4:0]   save_rob_tag;
  logic [127:0] save_rdy_table;
  logic         save_ready;
  logic [1:0]   save_id;
  logic         resolve_valid;
  logic         resolve_mispredict;
  logic [4:0]   resolve_rob_tag;
  logic         restore_valid;
  logic [31:0]  restore_pc;
  logic [4:0]   restore_rob_tag;
  logic [127:0] restore_rdy_table;
  logic         flush;
  logic [2:0]   count;
  logic         full;
  logic         empty;

  always #5 clk = ~clk;

  branch_checkpoint_unit #(.DEPTH(4), .IDXW(2), .TAGW(5), .RDYW(128)) dut (
    .clk(clk), .reset(reset),
    .save_valid(save_valid), .save_pc(save_pc), .save_rob_tag(save_rob_tag),
    .save_rdy_table(save_rdy_table), .save_ready(save_ready), .save_id(save_id),
    .resolve_valid(resolve_valid), .resolve_mispredict(resolve_mispredict),
    .resolve_rob_tag(resolve_rob_tag),
    .restore_valid(restore_valid), .restore_pc(restore_pc), .restore_rob_tag(restore_rob_tag),
    .restore_rdy_table(restore_rdy_table), .flush(flush),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    logic        ck, rst, sv;
    logic [4:0]  stag;
    logic [31:0] spc;
    logic [7:0]  stbl;
    logic        rv, rm;
    logic [4:0]  rtag;
    logic [2:0]  ecnt;
    logic        erdy;
    logic [1:0]  eid;
    logic        erv;
    logic [31:0] erpc;
    logic [4:0]  ertag;
    logic [7:0]  ertbl;
  } vec_t;

  vec_t  vecs[$];
  int    compared   = 0;
  int    mismatched = 0;
  string ctx;

  // reference model: slot contents plus unbounded head/tail counters
  logic         m_v   [4];
  logic [31:0]  m_pc  [4];
  logic [4:0]   m_tag [4];
  logic [127:0] m_tbl [4];
  int           mh, mt;
  logic         mrec, mrv;
  logic [31:0]  m_rpc;
  logic [4:0]   m_rtag;
  logic [127:0] m_rtbl;

  logic         r_rst, r_sv, r_rv, r_rm;
  logic [4:0]   r_stag, r_rtag;
  logic [31:0]  r_spc;
  logic [127:0] r_stbl;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", ctx, name, act, exp);
    end
  endtask

  function automatic void add(input logic ck, rst, sv, input logic [4:0] stag,
                              input logic [31:0] spc, input logic [7:0] stbl,
                              input logic rv, rm, input logic [4:0] rtag,
                              input logic [2:0] ecnt, input logic erdy, input logic [1:0] eid,
                              input logic erv, input logic [31:0] erpc,
                              input logic [4:0] ertag, input logic [7:0] ertbl);
    vec_t v;
    v.ck = ck; v.rst = rst; v.sv = sv; v.stag = stag; v.spc = spc; v.stbl = stbl;
    v.rv = rv; v.rm = rm; v.rtag = rtag; v.ecnt = ecnt; v.erdy = erdy; v.eid = eid;
    v.erv = erv; v.erpc = erpc; v.ertag = ertag; v.ertbl = ertbl;
    vecs.push_back(v);
  endfunction

  function automatic void rst_row();
    add(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 8'h0, 1'b0, 1'b0, 5'd0,
        3'd0, 1'b0, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
  endfunction

  function automatic void idl(input logic [2:0] c, input logic r, input logic [1:0] i,
                              input logic v, input logic [31:0] pc, input logic [4:0] t,
                              input logic [7:0] tb);
    add(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 8'h0, 1'b0, 1'b0, 5'd0, c, r, i, v, pc, t, tb);
  endfunction

  function automatic void sav(input logic [4:0] st, input logic [31:0] sp, input logic [7:0] sb,
                              input logic [2:0] c, input logic r, input logic [1:0] i,
                              input logic v, input logic [31:0] pc, input logic [4:0] t,
                              input logic [7:0] tb);
    add(1'b1, 1'b0, 1'b1, st, sp, sb, 1'b0, 1'b0, 5'd0, c, r, i, v, pc, t, tb);
  endfunction

  function automatic void rsl(input logic rm, input logic [4:0] rt,
                              input logic [2:0] c, input logic r, input logic [1:0] i,
                              input logic v, input logic [31:0] pc, input logic [4:0] t,
                              input logic [7:0] tb);
    add(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 8'h0, 1'b1, rm, rt, c, r, i, v, pc, t, tb);
  endfunction

  task automatic drive(input logic rst, sv, input logic [4:0] st, input logic [31:0] sp,
                       input logic [127:0] sb, input logic rv, rm, input logic [4:0] rt);
    reset = rst; save_valid = sv; save_rob_tag = st; save_pc = sp; save_rdy_table = sb;
    resolve_valid = rv; resolve_mispredict = rm; resolve_rob_tag = rt;
  endtask

  function automatic int m_find(input logic [4:0] t);
    for (int k = 0; k < 4; k++) if (m_v[k] && m_tag[k] == t) return k;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) m_v[k] = 1'b0;
    mh = 0; mt = 0; mrec = 1'b0; mrv = 1'b0;
    m_rpc = 32'h0; m_rtag = 5'd0; m_rtbl = 128'h0;
  endfunction

  // One clock edge of the reference behaviour, applied to the inputs seen during the cycle.
  function automatic void model_edge();
    int  k, off, nt;
    logic mis, cor, sr, ret;
    if (r_rst) begin
      model_reset();
      return;
    end
    k   = m_find(r_rtag);
    mis = !mrec && r_rv && r_rm && (k >= 0);
    cor = !mrec && r_rv && !r_rm && (k >= 0);
    sr  = !mrec && ((mt - mh) < 4) && !mis;
    ret = (mt != mh) && !m_v[mh % 4];
    if (mis) begin
      off = (k - (mh % 4) + 4) % 4;
      nt  = mh + off;
      for (int p = nt; p < mt; p++) m_v[p % 4] = 1'b0;
      mt = nt;
      m_rpc = m_pc[k]; m_rtag = m_tag[k]; m_rtbl = m_tbl[k];
    end
    mrv  = mis;
    mrec = mis;
    if (cor) m_v[k] = 1'b0;
    if (r_sv && sr) begin
      m_v[mt % 4] = 1'b1; m_pc[mt % 4] = r_spc; m_tag[mt % 4] = r_stag; m_tbl[mt % 4] = r_stbl;
      mt++;
    end
    if (ret) mh++;
  endfunction

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'h0, 128'h0, 1'b0, 1'b0, 5'd0);

    // fill, overflow drop, in-order free and wrap
    rst_row();
    idl(3'd0, 1'b1, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
    sav(5'd3, 32'h100, 8'h01, 3'd0, 1'b1, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
    sav(5'd4, 32'h104, 8'h02, 3'd1, 1'b1, 2'd1, 1'b0, 32'h0, 5'd0, 8'h0);
    sav(5'd5, 32'h108, 8'h04, 3'd2, 1'b1, 2'd2, 1'b0, 32'h0, 5'd0, 8'h0);
    sav(5'd6, 32'h10C, 8'h08, 3'd3, 1'b1, 2'd3, 1'b0, 32'h0, 5'd0, 8'h0);
    sav(5'd9, 32'h200, 8'hFF, 3'd4, 1'b0, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
    idl(3'd4, 1'b0, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
    rsl(1'b0, 5'd3, 3'd4, 1'b0, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
    rsl(1'b0, 5'd4, 3'd4, 1'b0, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
    idl(3'd3, 1'b1, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
    sav(5'd7, 32'h110, 8'h10, 3'd2, 1'b1, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
    idl(3'd3, 1'b1, 2'd1, 1'b0, 32'h0, 5'd0, 8'h0);
    // mispredict on a full buffer
    rst_row();
    sav(5'd3, 32'h100, 8'h01, 3'd0, 1'b1, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
    sav(5'd4, 32'h104, 8'h02, 3'd1, 1'b1, 2'd1, 1'b0, 32'h0, 5'd0, 8'h0);
    sav(5'd5, 32'h108, 8'h04, 3'd2, 1'b1, 2'd2, 1'b0, 32'h0, 5'd0, 8'h0);
    sav(5'd6, 32'h10C, 8'h08, 3'd3, 1'b1, 2'd3, 1'b0, 32'h0, 5'd0, 8'h0);
    rsl(1'b1, 5'd4, 3'd4, 1'b0, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
    idl(3'd1, 1'b0, 2'd1, 1'b1, 32'h104, 5'd4, 8'h02);
    idl(3'd1, 1'b1, 2'd1, 1'b0, 32'h104, 5'd4, 8'h02);
    rsl(1'b1, 5'd5, 3'd1, 1'b1, 2'd1, 1'b0, 32'h104, 5'd4, 8'h02);
    rsl(1'b0, 5'd3, 3'd1, 1'b1, 2'd1, 1'b0, 32'h104, 5'd4, 8'h02);
    idl(3'd1, 1'b1, 2'd1, 1'b0, 32'h104, 5'd4, 8'h02);
    idl(3'd0, 1'b1, 2'd1, 1'b0, 32'h104, 5'd4, 8'h02);
    // mispredict with a same-cycle save, RECOVER-time and unknown resolves, reset in RECOVER
    rst_row();
    sav(5'd3, 32'h100, 8'h01, 3'd0, 1'b1, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
    sav(5'd4, 32'h104, 8'h02, 3'd1, 1'b1, 2'd1, 1'b0, 32'h0, 5'd0, 8'h0);
    sav(5'd5, 32'h108, 8'h04, 3'd2, 1'b1, 2'd2, 1'b0, 32'h0, 5'd0, 8'h0);
    add(1'b1, 1'b0, 1'b1, 5'd9, 32'h200, 8'hFF, 1'b1, 1'b1, 5'd4,
        3'd3, 1'b0, 2'd3, 1'b0, 32'h0, 5'd0, 8'h0);
    rsl(1'b1, 5'd3, 3'd1, 1'b0, 2'd1, 1'b1, 32'h104, 5'd4, 8'h02);
    rsl(1'b1, 5'd9, 3'd1, 1'b1, 2'd1, 1'b0, 32'h104, 5'd4, 8'h02);
    rsl(1'b0, 5'd17, 3'd1, 1'b1, 2'd1, 1'b0, 32'h104, 5'd4, 8'h02);
    idl(3'd1, 1'b1, 2'd1, 1'b0, 32'h104, 5'd4, 8'h02);
    rsl(1'b1, 5'd3, 3'd1, 1'b0, 2'd1, 1'b0, 32'h104, 5'd4, 8'h02);
    add(1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 8'h0, 1'b0, 1'b0, 5'd0,
        3'd0, 1'b0, 2'd0, 1'b1, 32'h100, 5'd3, 8'h01);
    idl(3'd0, 1'b1, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
    // out-of-order free with a hole
    sav(5'd3, 32'h100, 8'h01, 3'd0, 1'b1, 2'd0, 1'b0, 32'h0, 5'd0, 8'h0);
    sav(5'd4, 32'h104, 8'h02, 3'd1, 1'b1, 2'd1, 1'b0, 32'h0, 5'd0, 8'h0);
    sav(5'd5, 32'h108, 8'h04, 3'd2, 1'b1, 2'd2, 1'b0, 32'h0, 5'd0, 8'h0);
    rsl(1'b0, 5'd5, 3'd3, 1'b1, 2'd3, 1'b0, 32'h0, 5'd0, 8'h0);
    idl(3'd3, 1'b1, 2'd3, 1'b0, 32'h0, 5'd0, 8'h0);
    rsl(1'b0, 5'd3, 3'd3, 1'b1, 2'd3, 1'b0, 32'h0, 5'd0, 8'h0);
    idl(3'd3, 1'b1, 2'd3, 1'b0, 32'h0, 5'd0, 8'h0);
    rsl(1'b0, 5'd4, 3'd2, 1'b1, 2'd3, 1'b0, 32'h0, 5'd0, 8'h0);
    idl(3'd2, 1'b1, 2'd3, 1'b0, 32'h0, 5'd0, 8'h0);
    idl(3'd1, 1'b1, 2'd3, 1'b0, 32'h0, 5'd0, 8'h0);
    idl(3'd0, 1'b1, 2'd3, 1'b0, 32'h0, 5'd0, 8'h0);

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      drive(vecs[n].rst, vecs[n].sv, vecs[n].stag, vecs[n].spc, 128'(vecs[n].stbl),
            vecs[n].rv, vecs[n].rm, vecs[n].rtag);
      #1;
      if (vecs[n].ck) begin
        ctx = $sformatf("vec%0d", n);
        chk("count", 128'(count), 128'(vecs[n].ecnt));
        chk("full", 128'(full), 128'(vecs[n].ecnt == 3'd4));
        chk("empty", 128'(empty), 128'(vecs[n].ecnt == 3'd0));
        chk("save_ready", 128'(save_ready), 128'(vecs[n].erdy));
        chk("save_id", 128'(save_id), 128'(vecs[n].eid));
        chk("restore_valid", 128'(restore_valid), 128'(vecs[n].erv));
        chk("flush", 128'(flush), 128'(vecs[n].erv));
        chk("restore_pc", 128'(restore_pc), 128'(vecs[n].erpc));
        chk("restore_rob_tag", 128'(restore_rob_tag), 128'(vecs[n].ertag));
        chk("restore_rdy_table", restore_rdy_table, 128'(vecs[n].ertbl));
      end
    end

    // randomized traffic against the reference model
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 128'h0, 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int   vq[$];
      int   k, cnt;
      logic mis;
      @(negedge clk);
      r_rst  = ($urandom_range(99, 0) == 0);
      r_sv   = ($urandom_range(1, 0) == 0);
      r_spc  = $urandom;
      r_stbl = {$urandom, $urandom, $urandom, $urandom};
      r_stag = 5'($urandom_range(31, 0));
      for (int t = 0; t < 64 && m_find(r_stag) >= 0; t++) r_stag = 5'($urandom_range(31, 0));
      if (m_find(r_stag) >= 0) r_sv = 1'b0;
      r_rv = ($urandom_range(4, 0) < 2);
      r_rm = ($urandom_range(3, 0) == 0);
      for (int s = 0; s < 4; s++) if (m_v[s]) vq.push_back(s);
      if (vq.size() > 0 && $urandom_range(4, 0) != 0)
        r_rtag = m_tag[vq[$urandom_range(vq.size() - 1, 0)]];
      else
        r_rtag = 5'($urandom_range(31, 0));
      drive(r_rst, r_sv, r_stag, r_spc, r_stbl, r_rv, r_rm, r_rtag);
      #1;
      ctx = $sformatf("rand%0d", cyc);
      k   = m_find(r_rtag);
      mis = !mrec && r_rv && r_rm && (k >= 0);
      cnt = mt - mh;
      chk("count", 128'(count), 128'(cnt));
      chk("full", 128'(full), 128'(cnt == 4));
      chk("empty", 128'(empty), 128'(cnt == 0));
      chk("save_ready", 128'(save_ready), 128'(!mrec && cnt < 4 && !mis));
      chk("save_id", 128'(save_id), 128'(mt % 4));
      chk("restore_valid", 128'(restore_valid), 128'(mrv));
      chk("flush", 128'(flush), 128'(mrv));
      chk("restore_pc", 128'(restore_pc), 128'(m_rpc));
      chk("restore_rob_tag", 128'(restore_rob_tag), 128'(m_rtag));
      chk("restore_rdy_table", restore_rdy_table, m_rtbl);
      @(posedge clk);
      model_edge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
